// File: rtl/mem_line_xfer.sv
// Line transfer initiator: optional victim writeback, then line refill.
// Optional watchdog on each memory transaction: define MEM_TIMEOUT_EN.
module mem_line_xfer #(
    parameter int ADDR_W    = 28,
    parameter int LINE_W    = 128,
    parameter int TO_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_dirty,
    input  logic [ADDR_W-1:0] vic_addr,
    input  logic [LINE_W-1:0] vic_data,
    output logic              busy,
    output logic              done,
    output logic [LINE_W-1:0] fill_data,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        GAP,
        RD,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [ADDR_W-1:0] lat_addr;
    logic              timeout;
    logic              in_xfer;

    assign in_xfer = (state == WB) || (state == RD);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign timeout = in_xfer && (cnt == CNT_W'(TO_CYCLES - 1));
    assign err     = err_q;

    // Per-transaction watchdog; clears whenever a WB or RD phase starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (in_xfer && (state_n == state)) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (timeout && !mem_ready) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_to;

    assign unused_to = (TO_CYCLES != 0);
    assign timeout   = 1'b0;
    assign err       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; mem_ready wins over a same-cycle timeout
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_n = req_dirty ? WB : RD;
                end
            end
            WB: begin
                if (mem_ready) begin
                    state_n = GAP;
                end else if (timeout) begin
                    state_n = DONE;
                end
            end
            GAP: begin
                state_n = RD;
            end
            RD: begin
                if (mem_ready || timeout) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fill_data <= '0;
            lat_addr  <= '0;
        end else begin
            busy      <= (state_n == WB) || (state_n == GAP)
                      || (state_n == RD);
            done      <= (state_n == DONE);
            mem_read  <= (state_n == RD);
            mem_write <= (state_n == WB);
            if ((state == IDLE) && req_valid) begin
                lat_addr <= req_addr;
                mem_addr <= req_dirty ? vic_addr : req_addr;
                if (req_dirty) begin
                    mem_wdata <= vic_data;
                end
            end
            if (state == GAP) begin
                mem_addr <= lat_addr;
            end
            if (state == RD) begin
                if (mem_ready) begin
                    fill_data <= mem_rdata;
                end else if (timeout) begin
                    fill_data <= '1;
                end
            end
        end
    end

endmodule
